// File: rtl/gcd_host.sv
// Host-side requester for the 8-bit GCD engine: buffers operand pairs in a FIFO,
// issues them one at a time with a START pulse, and returns DONE/ERROR/timeout results.
module gcd_host #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 600
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       IN_VALID,
  input  logic [7:0] IN_A,
  input  logic [7:0] IN_B,
  output logic       IN_READY,
  output logic       GCD_START,
  output logic [7:0] GCD_A,
  output logic [7:0] GCD_B,
  input  logic [7:0] GCD_Y,
  input  logic       GCD_DONE,
  input  logic       GCD_ERROR,
  output logic       RES_VALID,
  output logic [7:0] RES_Y,
  output logic       RES_ERR,
  output logic       RES_TIMEOUT,
  input  logic       RES_READY
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_a_q [DEPTH];
  logic [7:0]    mem_b_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic          start_q, start_d;
  logic [7:0]    gcd_a_q, gcd_a_d;
  logic [7:0]    gcd_b_q, gcd_b_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          res_valid_q, res_valid_d;
  logic [7:0]    res_y_q, res_y_d;
  logic          res_err_q, res_err_d;
  logic          res_to_q, res_to_d;
  logic          push;
  logic          pop;

  // Ready is a flop of the next count so it never depends on this cycle's inputs.
  assign push = IN_VALID && in_ready_q;
  assign pop  = (state_q == IDLE) && (count_q != '0);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d != FULL_CNT);
  end

  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    gcd_a_d     = gcd_a_q;
    gcd_b_d     = gcd_b_q;
    timer_d     = timer_q;
    res_valid_d = res_valid_q;
    res_y_d     = res_y_q;
    res_err_d   = res_err_q;
    res_to_d    = res_to_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = ISSUE;
          start_d = 1'b1;
          gcd_a_d = mem_a_q[rd_ptr_q];
          gcd_b_d = mem_b_q[rd_ptr_q];
        end
      end
      ISSUE: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: begin
        timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        // DONE takes priority over a watchdog expiry in the same cycle.
        if (GCD_DONE) begin
          state_d     = HOLD;
          res_valid_d = 1'b1;
          res_y_d     = GCD_ERROR ? 8'h00 : GCD_Y;
          res_err_d   = GCD_ERROR;
          res_to_d    = 1'b0;
        end else if (timer_q >= T_LAST) begin
          state_d     = HOLD;
          res_valid_d = 1'b1;
          res_y_d     = '0;
          res_err_d   = 1'b0;
          res_to_d    = 1'b1;
        end
      end
      HOLD: begin
        if (RES_READY) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      start_q     <= 1'b0;
      gcd_a_q     <= '0;
      gcd_b_q     <= '0;
      timer_q     <= '0;
      res_valid_q <= 1'b0;
      res_y_q     <= '0;
      res_err_q   <= 1'b0;
      res_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      start_q     <= start_d;
      gcd_a_q     <= gcd_a_d;
      gcd_b_q     <= gcd_b_d;
      timer_q     <= timer_d;
      res_valid_q <= res_valid_d;
      res_y_q     <= res_y_d;
      res_err_q   <= res_err_d;
      res_to_q    <= res_to_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= IN_A;
      mem_b_q[wr_ptr_q] <= IN_B;
    end
  end

  assign IN_READY    = in_ready_q;
  assign GCD_START   = start_q;
  assign GCD_A       = gcd_a_q;
  assign GCD_B       = gcd_b_q;
  assign RES_VALID   = res_valid_q;
  assign RES_Y       = res_y_q;
  assign RES_ERR     = res_err_q;
  assign RES_TIMEOUT = res_to_q;

endmodule

// File: tb/tb_gcd_host.sv
// Scoreboard bench for gcd_host: engine model with adjustable latency, stall and hang.
module tb_gcd_host;

  typedef struct {
    logic [7:0] y;
    logic       err;
    logic       to;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       in_ready;
  logic       gcd_start;
  logic [7:0] gcd_a, gcd_b;
  logic [7:0] gcd_y;
  logic       gcd_done;
  logic       gcd_error;
  logic       res_valid;
  logic [7:0] res_y;
  logic       res_err;
  logic       res_timeout;
  logic       res_ready = 1'b0;

  logic       eng_done = 1'b0;
  logic [7:0] eng_y = '0;
  logic       eng_err = 1'b0;
  logic       stray_done = 1'b0;
  logic [7:0] stray_y = '0;
  int         eng_delay = 5;
  logic       eng_never = 1'b0;
  logic       eng_stall = 1'b0;

  res_t        sb[$];
  logic [15:0] opq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          n_res = 0;

  assign gcd_done  = eng_done | stray_done;
  assign gcd_y     = stray_done ? stray_y : eng_y;
  assign gcd_error = eng_err & eng_done;

  gcd_host #(.DEPTH(4), .TIMEOUT(600)) dut (
    .CLK(clk), .RST_N(rst_n),
    .IN_VALID(in_valid), .IN_A(in_a), .IN_B(in_b), .IN_READY(in_ready),
    .GCD_START(gcd_start), .GCD_A(gcd_a), .GCD_B(gcd_b),
    .GCD_Y(gcd_y), .GCD_DONE(gcd_done), .GCD_ERROR(gcd_error),
    .RES_VALID(res_valid), .RES_Y(res_y), .RES_ERR(res_err),
    .RES_TIMEOUT(res_timeout), .RES_READY(res_ready)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gcd_ref(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, t;
    if (a == 0 || b == 0) return 8'h00;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Engine: DONE lands in WAIT cycle eng_delay (timer == eng_delay).
  initial begin
    int         cnt = 0;
    logic       pend = 1'b0;
    logic [7:0] ea = '0, eb = '0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (!rst_n) pend = 1'b0;
      else begin
        if (pend && !eng_stall) begin
          if (cnt == 0) begin
            eng_done = 1'b1;
            eng_y    = gcd_ref(ea, eb);
            eng_err  = (ea == 0 || eb == 0);
            pend     = 1'b0;
          end else cnt--;
        end
        if (gcd_start) begin
          ea   = gcd_a;
          eb   = gcd_b;
          cnt  = eng_delay;
          pend = !eng_never;
        end
      end
    end
  end

  // Monitor samples mid-low-phase, after drivers settle and before the next edge.
  initial begin
    logic        prev_start = 1'b0;
    res_t        e;
    logic [15:0] o;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (gcd_start) begin
          check_eq("start_pulse", prev_start, 0);
          if (opq.size() == 0) check_eq("unexp_start", gcd_start, 0);
          else begin
            o = opq.pop_front();
            check_eq("gcd_a", gcd_a, o[15:8]);
            check_eq("gcd_b", gcd_b, o[7:0]);
          end
        end
        if (res_valid && res_ready) begin
          if (sb.size() == 0) check_eq("unexp_res", res_valid, 0);
          else begin
            e = sb.pop_front();
            check_eq("res_y", res_y, e.y);
            check_eq("res_err", res_err, e.err);
            check_eq("res_to", res_timeout, e.to);
            n_res++;
          end
        end
      end
      prev_start = gcd_start;
    end
  end

  task automatic push_req(input logic [7:0] a, input logic [7:0] b, input logic to);
    int   n = 0;
    res_t e;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (!in_ready && n < 2000) begin @(negedge clk); n++; end
    if (!in_ready) check_eq("push_rdy", in_ready, 1);
    else begin
      e.to  = to;
      e.y   = to ? 8'h00 : gcd_ref(a, b);
      e.err = !to && (a == 0 || b == 0);
      sb.push_back(e);
      opq.push_back({a, b});
    end
    @(negedge clk);
  endtask

  task automatic wait_start(output int c);
    int n = 0;
    while (!gcd_start && n < 2000) begin @(negedge clk); n++; end
    if (!gcd_start) check_eq("start_tmo", gcd_start, 1);
    c = cyc;
  endtask

  task automatic wait_res(output int c);
    int n = 0;
    while (!res_valid && n < 1000) begin @(negedge clk); n++; end
    if (!res_valid) check_eq("res_tmo", res_valid, 1);
    c = cyc;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || res_valid) && n < 3000) begin @(negedge clk); n++; end
    check_eq("drain", sb.size(), 0);
  endtask

  initial begin
    int c0, c1, seen;

    // Reset and idle
    repeat (3) @(negedge clk);
    check_eq("rst_start", gcd_start, 0);
    check_eq("rst_a", gcd_a, 0);
    check_eq("rst_b", gcd_b, 0);
    check_eq("rst_valid", res_valid, 0);
    check_eq("rst_y", res_y, 0);
    check_eq("rst_err", res_err, 0);
    check_eq("rst_to", res_timeout, 0);
    check_eq("rst_rdy", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    stray_done = 1'b1;
    stray_y = 8'h55;
    @(negedge clk);
    stray_done = 1'b0;
    @(negedge clk);
    check_eq("stray_idle_valid", res_valid, 0);
    check_eq("stray_idle_y", res_y, 0);
    check_eq("idle_rdy", in_ready, 1);

    // Single request, result held under backpressure
    eng_delay = 5;
    push_req(8'd12, 8'd18, 1'b0);
    in_valid = 1'b0;
    wait_start(c0);
    wait_res(c1);
    check_eq("done_latency", c1 - c0, 7);
    for (int i = 0; i < 10; i++) begin
      check_eq("hold_valid", res_valid, 1);
      check_eq("hold_y", res_y, 6);
      check_eq("hold_to", res_timeout, 0);
      stray_done = (i == 2);
      @(negedge clk);
    end
    stray_done = 1'b0;

    // Fill the FIFO while the first result is still held
    push_req(8'd48, 8'd36, 1'b0);
    push_req(8'd7, 8'd13, 1'b0);
    push_req(8'd0, 8'd9, 1'b0);
    push_req(8'd255, 8'd85, 1'b0);
    in_a = 8'd100;
    in_b = 8'd100;
    check_eq("full_rdy", in_ready, 0);
    @(negedge clk);
    check_eq("full_hold_rdy", in_ready, 0);
    in_valid = 1'b0;
    eng_stall = 1'b1;
    res_ready = 1'b1;
    wait_start(c0);
    check_eq("rdy_after_pop", in_ready, 1);
    push_req(8'd100, 8'd100, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    eng_stall = 1'b0;
    wait_drain();

    // Watchdog expiry, then a normal request
    eng_never = 1'b1;
    push_req(8'd9, 8'd6, 1'b1);
    push_req(8'd8, 8'd12, 1'b0);
    in_valid = 1'b0;
    wait_start(c0);
    @(negedge clk);
    eng_never = 1'b0;
    wait_res(c1);
    check_eq("timeout_latency", c1 - c0, 601);
    check_eq("timeout_flag", res_timeout, 1);
    wait_drain();

    // DONE in the expiry cycle
    eng_delay = 599;
    push_req(8'd35, 8'd49, 1'b0);
    in_valid = 1'b0;
    wait_start(c0);
    @(negedge clk);
    eng_delay = 5;
    wait_res(c1);
    check_eq("edge_latency", c1 - c0, 601);
    check_eq("edge_to", res_timeout, 0);
    wait_drain();

    // Reset during WAIT with three requests queued
    eng_stall = 1'b1;
    push_req(8'd6, 8'd4, 1'b0);
    push_req(8'd10, 8'd15, 1'b0);
    push_req(8'd3, 8'd9, 1'b0);
    push_req(8'd20, 8'd30, 1'b0);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_start", gcd_start, 0);
    check_eq("mid_rst_a", gcd_a, 0);
    check_eq("mid_rst_valid", res_valid, 0);
    check_eq("mid_rst_rdy", in_ready, 1);
    sb.delete();
    opq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    eng_stall = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (res_valid || gcd_start) seen++;
    end
    check_eq("no_res_after_rst", seen, 0);
    push_req(8'd21, 8'd14, 1'b0);
    in_valid = 1'b0;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
